// File: rtl/memory_port_arbiter.sv
// Shares one multi-cycle backing-memory port between the I-cache refill
// path (IF) and the data-memory path (DM). DM wins ties unless IF has been
// passed over MAX_WAIT times in a row, in which case IF is forced through.
module memory_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_ack_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [ADDR_WIDTH-1:0] dm_addr_i,
  input  logic [DATA_WIDTH-1:0] dm_wdata_i,
  output logic                  dm_ack_o,
  output logic [DATA_WIDTH-1:0] dm_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SERVE_IF = 3'd1;
  localparam logic [2:0] SERVE_DM = 3'd2;
  localparam logic [2:0] RESP_IF  = 3'd3;
  localparam logic [2:0] RESP_DM  = 3'd4;

  // MAX_WAIT is limited to 1..15, so four bits hold the streak count.
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [2:0]            state_q,     state_d;
  logic [3:0]            streak_q,    streak_d;
  logic                  mem_we_q,    mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q,  dm_rdata_d;

  // Next-state logic: arbitration in IDLE, wait for mem_ready in SERVE,
  // single ack cycle in RESP.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      IDLE: begin
        if (dm_req_i && (!if_req_i || (streak_q < MAX_WAIT_C))) begin
          state_d     = SERVE_DM;
          mem_we_d    = dm_we_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          // Only count DM wins that actually made IF wait.
          if (!if_req_i) begin
            streak_d = 4'd0;
          end else if (streak_q != MAX_WAIT_C) begin
            streak_d = streak_q + 4'd1;
          end
        end else if (if_req_i) begin
          state_d     = SERVE_IF;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
          streak_d    = 4'd0;
        end
      end
      SERVE_IF: begin
        if (mem_ready_i) begin
          state_d    = RESP_IF;
          if_rdata_d = mem_rdata_i;
        end
      end
      SERVE_DM: begin
        if (mem_ready_i) begin
          state_d = RESP_DM;
          // Writes leave the previous read data visible.
          if (!mem_we_q) begin
            dm_rdata_d = mem_rdata_i;
          end
        end
      end
      RESP_IF, RESP_DM: state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      streak_q    <= 4'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  // Control outputs decode straight from the state register so an
  // asynchronous reset clears them without waiting for a clock edge.
  assign mem_req_o   = (state_q == SERVE_IF) || (state_q == SERVE_DM);
  assign if_ack_o    = (state_q == RESP_IF);
  assign dm_ack_o    = (state_q == RESP_DM);
  assign busy_o      = (state_q != IDLE);
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: reset values, a directed IF refill, an
// asynchronous reset mid-transaction, then randomized IF/DM traffic with a
// random-latency memory, checked against a transaction-level model.
module tb_memory_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, dm_req, dm_we, mem_ready;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata, mem_rdata;
  logic          if_ack_o, dm_ack_o, mem_req_o, mem_we_o, busy_o;
  logic [DW-1:0] if_rdata_o, dm_rdata_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clock_i     (clk),
    .reset_i     (rst),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_ack_o    (if_ack_o),
    .if_rdata_o  (if_rdata_o),
    .dm_req_i    (dm_req),
    .dm_we_i     (dm_we),
    .dm_addr_i   (dm_addr),
    .dm_wdata_i  (dm_wdata),
    .dm_ack_o    (dm_ack_o),
    .dm_rdata_o  (dm_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ready_i (mem_ready),
    .mem_rdata_i (mem_rdata),
    .busy_o      (busy_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model of the port: who owns it, whether memory has finished, what was latched.
  int            owner;      // 0 free, 1 IF, 2 DM
  bit            done;
  bit            ex_we;
  logic [AW-1:0] ex_addr;
  logic [DW-1:0] ex_wdata;
  logic [DW-1:0] m_if_rdata, m_dm_rdata;
  int            streak;
  int            txn;
  bit            if_prev_ack, dm_prev_ack;
  int            dm_pct;

  initial begin
    rst = 1'b1; if_req = 0; dm_req = 0; dm_we = 0; mem_ready = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", mem_req_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_if_ack", if_ack_o, 0);
    check("rst_dm_ack", dm_ack_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_mem_wdata", mem_wdata_o, 0);
    check("rst_mem_we", mem_we_o, 0);
    check("rst_if_rdata", if_rdata_o, 0);
    check("rst_dm_rdata", dm_rdata_o, 0);
    @(negedge clk) rst = 1'b0;

    // Directed IF refill: mem_ready in the third SERVE cycle.
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h40;
    @(posedge clk); #1;
    check("d1_mem_req_c1", mem_req_o, 1);
    check("d1_mem_addr", mem_addr_o, 32'h40);
    check("d1_mem_we", mem_we_o, 0);
    check("d1_busy", busy_o, 1);
    @(posedge clk); #1;
    check("d1_mem_req_c2", mem_req_o, 1);
    check("d1_if_ack_c2", if_ack_o, 0);
    @(posedge clk); #1;
    check("d1_mem_req_c3", mem_req_o, 1);
    mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    mem_ready = 0;
    check("d1_if_ack_c4", if_ack_o, 1);
    check("d1_if_rdata", if_rdata_o, 32'hDEADBEEF);
    check("d1_mem_req_c4", mem_req_o, 0);
    @(posedge clk); #1;
    if_req = 0;
    check("d1_if_ack_c5", if_ack_o, 0);
    check("d1_busy_c5", busy_o, 0);
    $display("txn directed: IF read addr=0x40 data=0x%0h", if_rdata_o);

    // Asynchronous reset in the middle of an IF transaction.
    if_req = 1; if_addr = 32'h44;
    @(posedge clk); #1;
    check("d5_mem_req_pre", mem_req_o, 1);
    #2 rst = 1'b1;
    #1;
    check("d5_mem_req", mem_req_o, 0);
    check("d5_busy", busy_o, 0);
    check("d5_if_ack", if_ack_o, 0);
    check("d5_mem_addr", mem_addr_o, 0);
    check("d5_if_rdata", if_rdata_o, 0);
    if_req = 0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("d5_busy_after", busy_o, 0);
    check("d5_if_ack_after", if_ack_o, 0);
    check("d5_mem_req_after", mem_req_o, 0);
    $display("txn directed: IF read addr=0x44 aborted by reset");

    // Randomized traffic.
    owner = 0; done = 0; ex_we = 0; ex_addr = '0; ex_wdata = '0;
    m_if_rdata = '0; m_dm_rdata = '0; streak = 0; txn = 0;
    if_prev_ack = 0; dm_prev_ack = 0;
    for (int c = 0; c < 3000; c++) begin
      check("busy", busy_o, owner != 0);
      check("mem_req", mem_req_o, owner != 0 && !done);
      check("if_ack", if_ack_o, owner == 1 && done);
      check("dm_ack", dm_ack_o, owner == 2 && done);
      if (owner != 0 && !done) begin
        check("mem_addr", mem_addr_o, ex_addr);
        check("mem_we", mem_we_o, ex_we);
        check("mem_wdata", mem_wdata_o, ex_wdata);
      end
      check("if_rdata", if_rdata_o, m_if_rdata);
      check("dm_rdata", dm_rdata_o, m_dm_rdata);

      // Requesters drop req on the edge where they saw their ack.
      if (if_prev_ack) if_req = 0;
      if (dm_prev_ack) dm_req = 0;
      if_prev_ack = if_ack_o;
      dm_prev_ack = dm_ack_o;

      dm_pct = (c < 1500) ? 40 : 90;
      if (!if_req && $urandom_range(99) < 30) begin
        if_req = 1; if_addr = $urandom;
      end
      if (!dm_req && $urandom_range(99) < dm_pct) begin
        dm_req = 1; dm_we = 1'($urandom_range(1)); dm_addr = $urandom; dm_wdata = $urandom;
      end
      // Inputs changing after the grant must not reach the memory port.
      if (owner == 1 && !done) if_addr = $urandom;
      if (owner == 2 && !done) begin
        dm_we = 1'($urandom_range(1)); dm_addr = $urandom; dm_wdata = $urandom;
      end
      mem_ready = ($urandom_range(99) < 45);
      mem_rdata = $urandom;

      // Advance the model by one cycle using this cycle's inputs.
      if (owner == 0) begin
        if (dm_req && (!if_req || streak < MW)) begin
          owner = 2; done = 0;
          ex_we = dm_we; ex_addr = dm_addr; ex_wdata = dm_wdata;
          streak = if_req ? ((streak < MW) ? streak + 1 : MW) : 0;
        end else if (if_req) begin
          owner = 1; done = 0;
          ex_we = 0; ex_addr = if_addr; ex_wdata = '0;
          streak = 0;
        end
      end else if (!done) begin
        if (mem_ready) begin
          done = 1;
          if (owner == 1) m_if_rdata = mem_rdata;
          else if (!ex_we) m_dm_rdata = mem_rdata;
        end
      end else begin
        txn++;
        $display("txn %0d: %s %s addr=0x%08h data=0x%08h streak=%0d", txn,
                 (owner == 1) ? "IF" : "DM", ex_we ? "write" : "read", ex_addr,
                 ex_we ? ex_wdata : ((owner == 1) ? m_if_rdata : m_dm_rdata), streak);
        owner = 0;
      end

      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
